// File: rtl/traffic_lamp_driver.sv
// Per-lane lamp driver behind the traffic FSM.
// Turns a one-hot lane grant into red/yellow/green lamps. Every handover goes
// through a timed yellow phase and then an all-red clearance, so two lanes are
// never non-red at the same time. A multi-hot grant latches a sticky fault.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_ALLRED | all lanes red; cnt counts clearance, then wait for a grant
//   S_GREEN  | granted lane green; holds while the grant stays the same
//   S_YELLOW | previous lane yellow for YELLOW_CYCLES; grant ignored
`timescale 1ns/1ps
module traffic_lamp_driver #(
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] grant,
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [3:0] red,
    output logic [1:0] phase,
    output logic       busy,
    output logic       fault
);

    localparam int CNT_MAX = (YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] YEL_INIT = CW'(YELLOW_CYCLES);
    localparam logic [CW-1:0] ALR_INIT = CW'(ALLRED_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_ALLRED = 2'b00,
        S_GREEN  = 2'b01,
        S_YELLOW = 2'b10
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    lane, lane_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    green_nxt, yellow_nxt, red_nxt;
    logic          busy_nxt;
    logic          multi_hot;
    logic          grant_valid;

    // Exactly-one-bit test without a popcount: clearing the lowest set bit must leave zero.
    assign multi_hot   = (grant & (grant - 4'd1)) != 4'd0;
    assign grant_valid = (grant != 4'd0) && !multi_hot;

    // The state register doubles as the phase code, so phase is registered too.
    assign phase = state;

    // State, lane, counter and lamp registers; lamps are decoded from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_ALLRED;
            lane   <= 4'd0;
            cnt    <= ALR_INIT;
            green  <= 4'd0;
            yellow <= 4'd0;
            red    <= 4'b1111;
            busy   <= 1'b1;
            fault  <= 1'b0;
        end else begin
            state  <= state_nxt;
            lane   <= lane_nxt;
            cnt    <= cnt_nxt;
            green  <= green_nxt;
            yellow <= yellow_nxt;
            red    <= red_nxt;
            busy   <= busy_nxt;
            fault  <= fault | multi_hot;
        end
    end

    // Next-state, counter and lamp decode.
    always_comb begin
        state_nxt = state;
        lane_nxt  = lane;
        cnt_nxt   = cnt;

        case (state)
            S_ALLRED: begin
                // cnt<=1 covers both the edge where the counter reaches zero and
                // any later edge where it already sits at zero.
                if (cnt <= CNT_ONE) begin
                    cnt_nxt = '0;
                    if (grant_valid) begin
                        state_nxt = S_GREEN;
                        lane_nxt  = grant;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_GREEN: begin
                if (grant != lane) begin
                    state_nxt = S_YELLOW;
                    cnt_nxt   = YEL_INIT;
                end
            end
            S_YELLOW: begin
                if (cnt <= CNT_ONE) begin
                    state_nxt = S_ALLRED;
                    cnt_nxt   = ALR_INIT;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_ALLRED;
                cnt_nxt   = ALR_INIT;
            end
        endcase

        green_nxt  = (state_nxt == S_GREEN)  ? lane_nxt : 4'd0;
        yellow_nxt = (state_nxt == S_YELLOW) ? lane_nxt : 4'd0;
        red_nxt    = ~(green_nxt | yellow_nxt);
        busy_nxt   = (state_nxt != S_GREEN) && (cnt_nxt != '0);
    end

endmodule
